// File: rtl/mac_accumulator.sv
// Windowed accumulator for partial products, with round/shift/clamp
// requantization and a ready/valid result register.
module mac_accumulator #(
  parameter int IN_W   = 14,
  parameter int BIAS_W = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 6,
  parameter int RELU   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [BIAS_W-1:0] bias,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [7:0]        out_count,
  output logic              out_sat
);

  localparam int RW = ACC_W + 1;

  localparam logic signed [RW-1:0] ZERO = '0;
  localparam logic signed [RW-1:0] RND  = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] UMAX = RW'((1 << OUT_W) - 1);
  localparam logic signed [RW-1:0] SMAX = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN = ~SMAX;

  typedef enum logic {IDLE, ACC} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_nx;
  logic [7:0]         cnt_q, cnt_d, cnt_nx;
  logic               vld_q, vld_d;
  logic [OUT_W-1:0]   dat_q, dat_d;
  logic [7:0]         ocnt_q, ocnt_d;
  logic               sat_q, sat_d;

  logic               fire;
  logic               take;
  logic [ACC_W-1:0]   din_x;
  logic [ACC_W-1:0]   bias_x;
  logic signed [RW-1:0] rsum;
  logic signed [RW-1:0] rq;
  logic [OUT_W-1:0]   qdat;
  logic               qsat;

  assign in_ready = !vld_q || out_ready;
  assign fire     = in_valid && in_ready;

  assign din_x  = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign bias_x = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};

  // A non-first beat only counts while a window is open.
  always_comb begin
    take   = 1'b0;
    acc_nx = acc_q;
    cnt_nx = cnt_q;
    if (in_first) begin
      take   = 1'b1;
      acc_nx = bias_x + din_x;
      cnt_nx = 8'd1;
    end else if (state_q == ACC) begin
      take   = 1'b1;
      acc_nx = acc_q + din_x;
      cnt_nx = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // One extra bit keeps the rounding add from wrapping.
  assign rsum = {acc_nx[ACC_W-1], acc_nx} + RND;
  assign rq   = rsum >>> SHIFT;

  always_comb begin
    qsat = 1'b0;
    qdat = rq[OUT_W-1:0];
    if (RELU != 0) begin
      if (rq < ZERO) begin
        qdat = '0;
      end else if (rq > UMAX) begin
        qdat = '1;
        qsat = 1'b1;
      end
    end else begin
      if (rq < SMIN) begin
        qdat = {1'b1, {(OUT_W-1){1'b0}}};
      end else if (rq > SMAX) begin
        qdat = {1'b0, {(OUT_W-1){1'b1}}};
        qsat = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q && !out_ready;
    dat_d   = dat_q;
    ocnt_d  = ocnt_q;
    sat_d   = sat_q;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (fire && take) begin
      acc_d = acc_nx;
      cnt_d = cnt_nx;
      if (in_last) begin
        state_d = IDLE;
        vld_d   = 1'b1;
        dat_d   = qdat;
        ocnt_d  = cnt_nx;
        sat_d   = qsat;
      end else begin
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      ocnt_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      ocnt_q  <= ocnt_d;
      sat_q   <= sat_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = dat_q;
  assign out_count = ocnt_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: one ReLU and one signed-clamp
// instance share the same stimulus.
module tb_mac_accumulator;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [13:0] in_data;
  logic               in_first;
  logic               in_last;
  logic signed [15:0] bias;
  logic               flush;
  logic               out_ready;

  logic       rdy1, vld1, sat1;
  logic [7:0] dat1, cnt1;
  logic       rdy0, vld0, sat0;
  logic [7:0] dat0, cnt0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.RELU(1)) u_relu (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_first(in_first),
    .in_last(in_last), .bias(bias),
    .flush(flush),
    .out_valid(vld1), .out_ready(out_ready),
    .out_data(dat1), .out_count(cnt1),
    .out_sat(sat1)
  );

  mac_accumulator #(.RELU(0)) u_sgn (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_first(in_first),
    .in_last(in_last), .bias(bias),
    .flush(flush),
    .out_valid(vld0), .out_ready(out_ready),
    .out_data(dat0), .out_count(cnt0),
    .out_sat(sat0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic f, input logic l,
                      input int d, input int b);
    @(negedge clk);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_data  = 14'(d);
    bias     = 16'(b);
    flush    = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic res(input string tag,
                     input logic v, input logic [7:0] d1,
                     input logic [7:0] d0, input logic [7:0] c,
                     input logic s1, input logic s0);
    chk({tag, "_v1"}, 32'(vld1), 32'(v));
    chk({tag, "_v0"}, 32'(vld0), 32'(v));
    chk({tag, "_d1"}, 32'(dat1), 32'(d1));
    chk({tag, "_d0"}, 32'(dat0), 32'(d0));
    chk({tag, "_c1"}, 32'(cnt1), 32'(c));
    chk({tag, "_c0"}, 32'(cnt0), 32'(c));
    chk({tag, "_s1"}, 32'(sat1), 32'(s1));
    chk({tag, "_s0"}, 32'(sat0), 32'(s0));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    bias      = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    res("rst", 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("rst_rdy", 32'(rdy1), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // single beat 640 -> 10
    beat(1, 1, 640, 0);
    idle();
    res("one", 1'b1, 8'd10, 8'd10, 8'd1, 1'b0, 1'b0);
    idle();
    chk("one_drop", 32'(vld1), 32'd0);

    // three-beat window with bias
    beat(1, 0, 100, 64);
    beat(0, 0, 200, 0);
    chk("three_b2", 32'(vld1), 32'd0);
    beat(0, 1, -50, 0);
    chk("three_b3", 32'(vld1), 32'd0);
    idle();
    res("three", 1'b1, 8'd5, 8'd5, 8'd3, 1'b0, 1'b0);

    // negative single beat
    beat(1, 1, -1000, 0);
    idle();
    res("neg", 1'b1, 8'd0, 8'hF0, 8'd1, 1'b0, 1'b0);

    // back-to-back single-beat windows
    beat(1, 1, 640, 0);
    beat(1, 1, 1280, 0);
    res("b2b1", 1'b1, 8'd10, 8'd10, 8'd1, 1'b0, 1'b0);
    beat(1, 1, -640, 0);
    res("b2b2", 1'b1, 8'd20, 8'd20, 8'd1, 1'b0, 1'b0);
    idle();
    res("b2b3", 1'b1, 8'd0, 8'hF6, 8'd1, 1'b0, 1'b0);

    // saturation, then hold under back-pressure
    beat(1, 0, 8191, 0);
    out_ready = 1'b0;
    beat(0, 0, 8191, 0);
    beat(0, 0, 8191, 0);
    beat(0, 1, 8191, 0);
    idle();
    res("sat", 1'b1, 8'd255, 8'd127, 8'd4, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      beat(1, 1, 640, 0);
      chk("hold_rdy", 32'(rdy1), 32'd0);
      res("hold", 1'b1, 8'd255, 8'd127, 8'd4, 1'b1, 1'b1);
    end
    beat(1, 1, 64, 0);
    out_ready = 1'b1;
    idle();
    res("swap", 1'b1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);

    // flush mid-window, then orphan beat
    beat(1, 0, 640, 0);
    beat(0, 0, 640, 0);
    idle();
    flush = 1'b1;
    beat(0, 1, 640, 0);
    idle();
    chk("flush_orph", 32'(vld1), 32'd0);
    idle();
    chk("flush_orph2", 32'(vld0), 32'd0);

    // beat accepted in flush cycle is discarded
    beat(1, 1, 640, 0);
    flush = 1'b1;
    idle();
    chk("flush_same", 32'(vld1), 32'd0);

    // beat counter saturates at 255
    beat(1, 0, 0, 0);
    for (int i = 0; i < 298; i++) beat(0, 0, 0, 0);
    beat(0, 1, 0, 0);
    idle();
    res("cnt", 1'b1, 8'd0, 8'd0, 8'd255, 1'b0, 1'b0);

    // async reset with a pending result
    out_ready = 1'b0;
    beat(1, 1, 640, 0);
    idle();
    chk("pre_rst_v", 32'(vld1), 32'd1);
    #2 reset = 1'b1;
    #1;
    res("arst", 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;

    // async reset mid-window drops the window
    beat(1, 0, 640, 0);
    beat(0, 0, 640, 0);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    beat(0, 1, 640, 0);
    idle();
    chk("rst_win", 32'(vld1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
